ro_freq_meter: RTL and testbench

//  Control and readout end of the on-chip ring oscillator (RO) aging sensor.

---
 rtl/ro_meter_pkg.sv | 26 ++
 rtl/ro_freq_meter_if.sv | 26 ++
 rtl/ro_edge_sync.sv | 27 ++
 rtl/ro_freq_meter.sv | 134 +++++++++++++
 tb/tb_ro_freq_meter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ro_meter_pkg.sv
// Shared types and constants for the ring-oscillator aging-sensor meter.
package ro_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STRESS,
    SETTLE,
    MEASURE,
    DONE
  } state_t;

  localparam int DEF_CNT_W         = 16;
  localparam int DEF_GATE_W        = 16;
  localparam int DEF_STRESS_W      = 24;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_SYNC_STAGES   = 2;

  // Floors that keep the synchronizer primed before the gate opens.
  localparam int MIN_SETTLE_CYCLES = 3;
  localparam int MIN_SYNC_STAGES   = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_freq_meter_if.sv
// Host-side control/readout bundle of the RO frequency meter.
interface ro_freq_meter_if
  import ro_meter_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int GATE_W   = DEF_GATE_W,
  parameter int STRESS_W = DEF_STRESS_W
);
  logic                start;
  logic [GATE_W-1:0]   gate_len;
  logic [STRESS_W-1:0] stress_len;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    count;
  logic                overflow;

  modport master (
    output start, gate_len, stress_len,
    input  busy, done, count, overflow
  );

  modport slave (
    input  start, gate_len, stress_len,
    output busy, done, count, overflow
  );
endinterface

// File: rtl/ro_edge_sync.sv
// Brings the asynchronous RO output into clk and flags each synced rising edge.
module ro_edge_sync
  import ro_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic ro_in,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: non-blocking assignments make every stage sample the previous stage's old value, forming a real shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/ro_freq_meter.sv
// RO aging-sensor controller: stress -> settle -> gated edge count -> done.
// Optional STRESS phase is built only when RO_STRESS_EN is defined.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int GATE_W        = DEF_GATE_W,
  parameter int STRESS_W      = DEF_STRESS_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic           clk,
  input  logic           rst,
  ro_freq_meter_if.slave host,
  input  logic           ro_in,
  output logic           ro_mode,
  output logic           ro_stress
);
  localparam int SETTLE_N = max_int(SETTLE_CYCLES, MIN_SETTLE_CYCLES);
  localparam int SYNC_N   = max_int(SYNC_STAGES, MIN_SYNC_STAGES);
  localparam int PH_W     = max_int(max_int(GATE_W, STRESS_W), $clog2(SETTLE_N + 1));

  localparam logic [PH_W-1:0]  PH_ONE      = PH_W'(1);
  localparam logic [PH_W-1:0]  SETTLE_LOAD = PH_W'(SETTLE_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [GATE_W-1:0] gate_q;
  logic              rise;

  ro_edge_sync #(.SYNC_STAGES(SYNC_N)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .ro_in (ro_in),
    .rise  (rise)
  );

`ifdef RO_STRESS_EN
  logic stress_q;
  assign ro_stress = stress_q;
`else
  logic unused_stress;
  assign unused_stress = ^host.stress_len;
  assign ro_stress     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      phase         <= '0;
      gate_q        <= '0;
      ro_mode       <= 1'b0;
      host.busy     <= 1'b0;
      host.done     <= 1'b0;
      host.count    <= '0;
      host.overflow <= 1'b0;
`ifdef RO_STRESS_EN
      stress_q      <= 1'b0;
`endif
    end else begin
      host.done <= 1'b0;
      case (state)
        IDLE: begin
          if (host.start) begin
            gate_q        <= host.gate_len;
            host.count    <= '0;
            host.overflow <= 1'b0;
            host.busy     <= 1'b1;
`ifdef RO_STRESS_EN
            if (host.stress_len != '0) begin
              state    <= STRESS;
              phase    <= PH_W'(host.stress_len) - PH_ONE;
              stress_q <= 1'b1;
            end else begin
              state   <= SETTLE;
              phase   <= SETTLE_LOAD;
              ro_mode <= 1'b1;
            end
`else
            state   <= SETTLE;
            phase   <= SETTLE_LOAD;
            ro_mode <= 1'b1;
`endif
          end
        end
`ifdef RO_STRESS_EN
        STRESS: begin
          if (phase == '0) begin
            state    <= SETTLE;
            phase    <= SETTLE_LOAD;
            stress_q <= 1'b0;
            ro_mode  <= 1'b1;
          end else begin
            phase <= phase - PH_ONE;
          end
        end
`endif
        SETTLE: begin
          // A zero gate length still opens the window for one cycle.
          if (phase == '0) begin
            state <= MEASURE;
            phase <= (gate_q == '0) ? '0 : PH_W'(gate_q) - PH_ONE;
          end else begin
            phase <= phase - PH_ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            if (host.count == CNT_MAX) host.overflow <= 1'b1;
            else                       host.count    <= host.count + CNT_ONE;
          end
          if (phase == '0) begin
            state     <= DONE;
            host.done <= 1'b1;
            ro_mode   <= 1'b0;
          end else begin
            phase <= phase - PH_ONE;
          end
        end
        DONE: begin
          state     <= IDLE;
          host.busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          host.busy <= 1'b0;
          ro_mode   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: a 16-bit meter and a 4-bit (saturating) meter share clk, rst and ro_in.
module tb_ro_freq_meter;
  localparam int SETTLE = 8;
  localparam int SAT_MAX = 15;

  typedef struct {
    int   gate_len;
    int   stress_len;
    int   ro_half;   // half period of ro_in in ns; 0 = hold ro_hold
    logic ro_hold;
    int   cnt_min;
    int   cnt_max;
  } vec_t;

  logic clk;
  logic rst;
  logic ro_in;
  logic ro_mode_m, ro_stress_m, ro_mode_s, ro_stress_s;
  int   ro_half;
  logic ro_hold;
  int   n_checks;
  int   n_errors;

  ro_freq_meter_if #(.CNT_W(16), .GATE_W(16), .STRESS_W(24)) hm ();
  ro_freq_meter_if #(.CNT_W(4),  .GATE_W(16), .STRESS_W(24)) hs ();

  ro_freq_meter #(.CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .host      (hm),
    .ro_in     (ro_in),
    .ro_mode   (ro_mode_m),
    .ro_stress (ro_stress_m)
  );

  ro_freq_meter #(.CNT_W(4)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .host      (hs),
    .ro_in     (ro_in),
    .ro_mode   (ro_mode_s),
    .ro_stress (ro_stress_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RO edges land at 3 mod 5 ns, never on a clock edge.
  initial begin
    ro_in = 1'b0;
    #3;
    forever begin
      if (ro_half == 0) begin
        ro_in = ro_hold;
        #5;
      end else begin
        #(ro_half) ro_in = ~ro_in;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    n_checks++;
    if (actual < lo || actual > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic run_vector(input int idx, input vec_t v, input int poke_at);
    int    n_done, n_done_s, n_mode, n_stress, done_at, idle_at, gate_eff, exp_stress;
    string tag;
    tag = $sformatf("v%0d", idx);
    ro_half = v.ro_half;
    ro_hold = v.ro_hold;
    repeat (6) @(negedge clk);
    hm.gate_len = 16'(v.gate_len);   hs.gate_len = 16'(v.gate_len);
    hm.stress_len = 24'(v.stress_len); hs.stress_len = 24'(v.stress_len);
    hm.start = 1'b1; hs.start = 1'b1;
    @(negedge clk);
    hm.start = 1'b0; hs.start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(hm.busy), 32'd1);

    n_done = 0; n_done_s = 0; n_mode = 0; n_stress = 0; done_at = -1; idle_at = -1;
    for (int cyc = 0; cyc < 2000 && idle_at < 0; cyc++) begin
      if (ro_mode_m)   n_mode++;
      if (ro_stress_m) n_stress++;
      if (hm.done) begin
        n_done++;
        done_at = cyc;
      end
      if (hs.done) n_done_s++;
      if (!hm.busy && !hs.busy) begin
        idle_at = cyc;
      end else begin
        hm.start = (cyc == poke_at);
        hs.start = (cyc == poke_at);
        if (cyc == poke_at) begin
          hm.gate_len = 16'd5;
          hs.gate_len = 16'd5;
        end
        @(negedge clk);
      end
    end
    hm.start = 1'b0; hs.start = 1'b0;

    gate_eff = (v.gate_len == 0) ? 1 : v.gate_len;
`ifdef RO_STRESS_EN
    exp_stress = v.stress_len;
`else
    exp_stress = 0;
`endif
    check({tag, "_finished"}, 32'(idle_at >= 0), 32'd1);
    check_range({tag, "_count"}, int'(hm.count), v.cnt_min, v.cnt_max);
    check({tag, "_overflow"}, 32'(hm.overflow), 32'd0);
    if (v.cnt_min > SAT_MAX) begin
      check({tag, "_sat_count"}, 32'(hs.count), 32'(SAT_MAX));
      check({tag, "_sat_overflow"}, 32'(hs.overflow), 32'd1);
    end else begin
      check_range({tag, "_sat_count"}, int'(hs.count), v.cnt_min, v.cnt_max);
      check({tag, "_sat_overflow"}, 32'(hs.overflow), 32'd0);
    end
    check({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    check({tag, "_sat_done_pulses"}, 32'(n_done_s), 32'd1);
    check({tag, "_ro_mode_cycles"}, 32'(n_mode), 32'(SETTLE + gate_eff));
    check({tag, "_ro_stress_cycles"}, 32'(n_stress), 32'(exp_stress));
    check({tag, "_busy_drop_after_done"}, 32'(idle_at - done_at), 32'd1);
  endtask

  vec_t vecs[6];
  int   n_bad;

  initial begin
    n_checks = 0;
    n_errors = 0;
    ro_half  = 0;
    ro_hold  = 1'b0;
    vecs[0] = '{100,  0, 20, 1'b0, 24, 26};  // period 4 clk
    vecs[1] = '{ 50,  0,  0, 1'b1,  0,  0};  // RO stuck high
    vecs[2] = '{ 60,  0, 15, 1'b0, 19, 21};  // period 3 clk, 4-bit meter saturates
    vecs[3] = '{  0,  0, 20, 1'b0,  0,  1};  // zero gate -> one-cycle window
    vecs[4] = '{ 20, 10, 20, 1'b0,  4,  6};  // stress phase
    vecs[5] = '{  1,  0, 20, 1'b0,  0,  1};  // minimum gate

    rst = 1'b1;
    hm.start = 1'b0; hm.gate_len = '0; hm.stress_len = '0;
    hs.start = 1'b0; hs.gate_len = '0; hs.stress_len = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(hm.busy), 32'd0);
    check("rst_done", 32'(hm.done), 32'd0);
    check("rst_count", 32'(hm.count), 32'd0);
    check("rst_overflow", 32'(hm.overflow), 32'd0);
    check("rst_ro_mode", 32'(ro_mode_m), 32'd0);
    check("rst_ro_stress", 32'(ro_stress_m), 32'd0);
    check("rst_sat_count", 32'(hs.count), 32'd0);
    check("rst_sat_busy", 32'(hs.busy), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vector(i, vecs[i], -1);

    // start pulsed mid-MEASURE must be ignored: window stays 30 cycles, one done.
    run_vector(6, '{30, 0, 20, 1'b0, 6, 9}, SETTLE + 15);

    // Reset mid-MEASURE aborts at once and never produces done.
    ro_half = 20;
    repeat (4) @(negedge clk);
    hm.gate_len = 16'd100; hs.gate_len = 16'd100;
    hm.stress_len = '0;    hs.stress_len = '0;
    hm.start = 1'b1; hs.start = 1'b1;
    @(negedge clk);
    hm.start = 1'b0; hs.start = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_busy_before_rst", 32'(hm.busy), 32'd1);
    check("mid_ro_mode_before_rst", 32'(ro_mode_m), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(hm.busy), 32'd0);
    check("abort_ro_mode", 32'(ro_mode_m), 32'd0);
    check("abort_ro_stress", 32'(ro_stress_m), 32'd0);
    check("abort_count", 32'(hm.count), 32'd0);
    check("abort_done", 32'(hm.done), 32'd0);
    check("abort_sat_count", 32'(hs.count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (hm.done || hm.busy || ro_mode_m) n_bad++;
    end
    check("abort_stays_idle", 32'(n_bad), 32'd0);

    run_vector(7, '{20, 0, 20, 1'b0, 4, 6}, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
